// File: rtl/pipeline_stall_controller_if.sv
// ============================================================================
// pipeline_stall_controller_if : hazard requests in, pipeline-register controls
//                                and stall/flush statistics out
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipeline_stall_controller_if #(
   parameter int CNT_W = 16
);
   logic             hazard_req;
   logic             id_branch_taken;
   logic             mem_busy;
   logic             clear_stats;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic             stall_timeout;

   modport master (
      output hazard_req, id_branch_taken, mem_busy, clear_stats,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
      input  stall_count, flush_count, stall_timeout
   );

   modport slave (
      input  hazard_req, id_branch_taken, mem_busy, clear_stats,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble,
      output stall_count, flush_count, stall_timeout
   );
endinterface

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// ============================================================================
// pipeline_stall_controller : PC / IF-ID / ID-EX stall, flush and freeze control
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_controller #(
   parameter int CNT_W        = 16,
   parameter int MAX_STALL    = 8,
   parameter int FLUSH_CYCLES = 1
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   pipeline_stall_controller_if.slave  bus
);

   localparam int             c_run_w      = $clog2(MAX_STALL + 1);
   localparam logic [CNT_W-1:0] c_cnt_max  = '1;
   localparam logic [c_run_w-1:0] c_run_max  = c_run_w'(MAX_STALL);
   localparam logic [c_run_w-1:0] c_run_trip = c_run_w'(MAX_STALL - 1);
   localparam logic [3:0]     c_flush_load = 4'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      STALL  = 2'd2,
      FREEZE = 2'd3
   } state_t;

   state_t               r_state;
   state_t               r_resume;
   state_t               w_state_nxt;
   state_t               w_resume_nxt;
   state_t               w_cur;
   logic [3:0]           r_flush_left;
   logic [3:0]           w_flush_left_nxt;
   logic [c_run_w-1:0]   r_stall_run;
   logic [CNT_W-1:0]     r_stall_count;
   logic [CNT_W-1:0]     r_flush_count;
   logic                 r_stall_timeout;
   logic                 w_flush_pending;
   logic                 w_stall_inc;
   logic                 w_flush_inc;
   logic                 w_pc_write;
   logic                 w_if_id_write;
   logic                 w_if_id_flush;
   logic                 w_id_ex_bubble;

   // A frozen cycle is transparent: decide as if still in the pre-freeze state.
   assign w_cur           = (r_state == FREEZE) ? r_resume : r_state;
   assign w_flush_pending = ((w_cur == FLUSH) || (w_cur == STALL)) && (r_flush_left != 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RUN;
         r_resume     <= RUN;
         r_flush_left <= 4'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_resume     <= w_resume_nxt;
         r_flush_left <= w_flush_left_nxt;
      end
   end

   always_comb begin
      w_pc_write       = 1'b1;
      w_if_id_write    = 1'b1;
      w_if_id_flush    = 1'b0;
      w_id_ex_bubble   = 1'b0;
      w_state_nxt      = RUN;
      w_resume_nxt     = r_resume;
      w_flush_left_nxt = r_flush_left;
      w_stall_inc      = 1'b0;
      w_flush_inc      = 1'b0;

      if (bus.mem_busy) begin
         w_pc_write    = 1'b0;
         w_if_id_write = 1'b0;
         w_state_nxt   = FREEZE;
         w_resume_nxt  = w_cur;
      end else if (bus.hazard_req) begin
         // ID is held, so a branch seen now re-presents next cycle.
         w_pc_write     = 1'b0;
         w_if_id_write  = 1'b0;
         w_id_ex_bubble = 1'b1;
         w_stall_inc    = 1'b1;
         w_state_nxt    = STALL;
      end else if (w_flush_pending) begin
         w_if_id_flush    = 1'b1;
         w_flush_left_nxt = r_flush_left - 4'd1;
         w_state_nxt      = (r_flush_left == 4'd1) ? RUN : FLUSH;
      end else if (bus.id_branch_taken) begin
         w_if_id_flush    = 1'b1;
         w_flush_inc      = 1'b1;
         w_flush_left_nxt = c_flush_load;
         w_state_nxt      = (c_flush_load != 4'd0) ? FLUSH : RUN;
      end

      // Pipe must keep moving while in reset regardless of request inputs.
      if (!rst_n) begin
         w_pc_write     = 1'b1;
         w_if_id_write  = 1'b1;
         w_if_id_flush  = 1'b0;
         w_id_ex_bubble = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_run <= '0;
      end else if (bus.mem_busy) begin
         r_stall_run <= r_stall_run;
      end else if (bus.hazard_req) begin
         if (r_stall_run != c_run_max) begin
            r_stall_run <= r_stall_run + 1'b1;
         end
      end else begin
         r_stall_run <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count   <= '0;
         r_flush_count   <= '0;
         r_stall_timeout <= 1'b0;
      end else if (bus.clear_stats) begin
         r_stall_count   <= '0;
         r_flush_count   <= '0;
         r_stall_timeout <= 1'b0;
      end else begin
         if (w_stall_inc && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + 1'b1;
         end
         if (w_flush_inc && (r_flush_count != c_cnt_max)) begin
            r_flush_count <= r_flush_count + 1'b1;
         end
         if (w_stall_inc && (r_stall_run >= c_run_trip)) begin
            r_stall_timeout <= 1'b1;
         end
      end
   end

   assign bus.pc_write      = w_pc_write;
   assign bus.if_id_write   = w_if_id_write;
   assign bus.if_id_flush   = w_if_id_flush;
   assign bus.id_ex_bubble  = w_id_ex_bubble;
   assign bus.stall_count   = r_stall_count;
   assign bus.flush_count   = r_flush_count;
   assign bus.stall_timeout = r_stall_timeout;

endmodule

`default_nettype wire
